// File: rtl/uart_rx_frame_parser.sv
// uart_rx_frame_parser
//   Pops bytes from the UART receive FIFO, hunts for the start-of-frame
//   marker and parses frames of the form SOF | LEN | PAYLOAD[LEN] | CHK.
//   Payload bytes are forwarded on a registered valid/ready stream with a
//   last marker. A one-cycle frame_done pulse reports the outcome of every
//   frame: ok, checksum error, length error, line error or timeout.
//
//   The checksum covers LEN and every payload byte. A frame is good when
//   (LEN + sum(PAYLOAD) + CHK) mod 256 == 0.
//
//   Optional feature: define UART_PARSER_TIMEOUT_EN to add the to_cycles
//   port and an inter-byte timeout that aborts a stalled frame. Without the
//   macro a frame waits indefinitely for its next byte.

module uart_rx_frame_parser #(
  parameter logic [7:0] SOF_BYTE = 8'h7E,
  parameter int         MAX_LEN  = 64
`ifdef UART_PARSER_TIMEOUT_EN
  ,
  parameter int         TO_BITS  = 16
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rx_empty,
  input  logic [7:0]         data_r,
  input  logic               rx_line_err,
  output logic               rd_uart,
  output logic [7:0]         out_data,
  output logic               out_valid,
  output logic               out_last,
  input  logic               out_ready,
  output logic               frame_done,
  output logic               frame_ok,
  output logic [2:0]         err_code
`ifdef UART_PARSER_TIMEOUT_EN
  ,
  input  logic [TO_BITS-1:0] to_cycles
`endif
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LEN  = 2'd1;
  localparam logic [1:0] ST_PAY  = 2'd2;
  localparam logic [1:0] ST_CHK  = 2'd3;

  localparam logic [2:0] ERR_OK      = 3'd0;
  localparam logic [2:0] ERR_CHK     = 3'd1;
  localparam logic [2:0] ERR_LEN     = 3'd2;
  localparam logic [2:0] ERR_LINE    = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT = 3'd4;

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  logic [1:0] state;
  logic [7:0] sum;
  logic [7:0] count;
  logic [7:0] len;
  logic       fetch_pend;
  logic       line_abort;
  logic       to_hit;
  logic       abort_any;
  logic [7:0] chk_total;
  logic       pay_is_last;

  // A line error only matters once a frame has started; in IDLE it is noise.
  assign line_abort = rx_line_err && (state != ST_IDLE);

`ifdef UART_PARSER_TIMEOUT_EN
  logic [TO_BITS-1:0] to_cnt;
  logic [TO_BITS-1:0] to_cnt_next;

  assign to_cnt_next = to_cnt + {{(TO_BITS-1){1'b0}}, 1'b1};

  // Fires on the cycle the counter would reach the limit; a zero limit disables it.
  assign to_hit = (state != ST_IDLE) && (to_cycles != '0) && (to_cnt_next == to_cycles);

  // Inter-byte timer: restarts on every captured byte and only runs inside a frame.
  always_ff @(posedge clk) begin
    if (reset || (state == ST_IDLE) || fetch_pend || abort_any) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt_next;
    end
  end
`else
  assign to_hit = 1'b0;
`endif

  assign abort_any   = line_abort || to_hit;
  assign chk_total   = sum + data_r;
  assign pay_is_last = (count == (len - 8'd1));

  // Every state consumes bytes, so a pop is issued whenever the FIFO has data,
  // no earlier pop is still being captured, the output register is free and
  // the frame is not being aborted this cycle (so no byte is popped only to be lost).
  assign rd_uart = !reset && !abort_any && !fetch_pend && !out_valid && !rx_empty;

  // Frame FSM, checksum/count bookkeeping, output register and status pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      sum        <= 8'h00;
      count      <= 8'h00;
      len        <= 8'h00;
      fetch_pend <= 1'b0;
      out_data   <= 8'h00;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      frame_done <= 1'b0;
      frame_ok   <= 1'b0;
      err_code   <= ERR_OK;
    end else begin
      frame_done <= 1'b0;
      frame_ok   <= 1'b0;
      err_code   <= ERR_OK;
      fetch_pend <= rd_uart;

      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end

      if (abort_any) begin
        frame_done <= 1'b1;
        err_code   <= line_abort ? ERR_LINE : ERR_TIMEOUT;
        state      <= ST_IDLE;
        if (out_valid && !out_ready) begin
          out_last <= 1'b1;
        end
      end else if (fetch_pend) begin
        case (state)
          ST_IDLE: begin
            if (data_r == SOF_BYTE) begin
              sum   <= 8'h00;
              count <= 8'h00;
              state <= ST_LEN;
            end
          end
          ST_LEN: begin
            sum   <= data_r;
            len   <= data_r;
            count <= 8'h00;
            if (data_r > MAX_LEN_B) begin
              frame_done <= 1'b1;
              err_code   <= ERR_LEN;
              state      <= ST_IDLE;
            end else if (data_r == 8'h00) begin
              state <= ST_CHK;
            end else begin
              state <= ST_PAY;
            end
          end
          ST_PAY: begin
            out_data  <= data_r;
            out_valid <= 1'b1;
            out_last  <= pay_is_last;
            sum       <= sum + data_r;
            count     <= count + 8'd1;
            if (pay_is_last) begin
              state <= ST_CHK;
            end
          end
          ST_CHK: begin
            frame_done <= 1'b1;
            frame_ok   <= (chk_total == 8'h00);
            err_code   <= (chk_total == 8'h00) ? ERR_OK : ERR_CHK;
            state      <= ST_IDLE;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule
